spi_ldo_ramp_sequencer: RTL and testbench

- Sits upstream of the LDO SPI master. Holds a per-channel target code for up to NUM_CH LDO channels and ramps each channel's programmed code toward its target in bounded steps.
- Formats each step as one 32-bit command word and pushes it into the SPI master's command write port. Words are paced by a minimum inter-command gap, because the SPI master exposes no busy or full signal.
- Host-side configuration and SPI command issue share a single clock.

---
 rtl/spi_ldo_ramp_sequencer_pkg.sv | 30 +++
 rtl/spi_ldo_ramp_sequencer_if.sv | 11 +
 rtl/spi_ldo_ramp_sequencer_step_calc.sv | 16 +
 rtl/spi_ldo_ramp_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_spi_ldo_ramp_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ldo_ramp_sequencer_pkg.sv
// Shared definitions for the LDO ramp sequencer.
// Contents: FSM state encodings, command-word field offsets, and the clamped step helper.
package spi_ldo_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // The data half-word sits in the upper half and is shifted out first by the SPI master.
  // The slave-select half-word sits in the lower half.
  localparam int DATA_LSB = 16;
  localparam int SS_LSB   = 0;

  // Move cur toward tgt by at most step, never past tgt.
  // Codes are carried at 16 bits so any code width up to 16 fits.
  function automatic logic [15:0] clampStep(input logic [15:0] cur,
                                            input logic [15:0] tgt,
                                            input logic [15:0] step);
    logic [15:0] diff;
    logic [15:0] delta;
    logic        up;
    up    = (tgt >= cur);
    diff  = up ? (tgt - cur) : (cur - tgt);
    delta = (diff < step) ? diff : step;
    clampStep = up ? (cur + delta) : (cur - delta);
  endfunction

endpackage

// File: rtl/spi_ldo_ramp_sequencer_if.sv
// Command push bus from the ramp sequencer into the LDO SPI master's write port.
// The sequencer drives the bus, so it connects through the master modport.
interface spi_ldo_ramp_sequencer_if;

  logic        spi_wr_en;
  logic [31:0] spi_wr_data;

  modport master (output spi_wr_en, output spi_wr_data);
  modport slave  (input  spi_wr_en, input  spi_wr_data);

endinterface

// File: rtl/spi_ldo_ramp_sequencer_step_calc.sv
// Combinational next-code calculation for one LDO channel.
// This module is kept on its own so the clamp can be exercised in isolation.
module spi_ldo_step_calc
  import spi_ldo_pkg::*;
#(
  parameter int CODE_W = 11,
  parameter int STEP   = 16
) (
  input  logic [CODE_W-1:0] i_current,
  input  logic [CODE_W-1:0] i_target,
  output logic [CODE_W-1:0] o_next
);

  assign o_next = CODE_W'(clampStep(16'(i_current), 16'(i_target), 16'(STEP)));

endmodule

// File: rtl/spi_ldo_ramp_sequencer.sv
// LDO ramp sequencer: holds per-channel target codes and walks each channel's
// programmed code toward its target in bounded steps, one paced SPI command per step.
// Optional build macro: LDO_REFRESH_EN. When it is defined, a periodic refresh
// rewrites every channel after a long quiet interval in idle.
module spi_ldo_ramp_sequencer
  import spi_ldo_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int CODE_W         = 11,
  parameter int STEP           = 16,
  parameter int GAP_CYCLES     = 600,
  parameter int INIT_CODE      = 0,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_cfg_we,
  input  logic [2:0]          i_cfg_ch,
  input  logic [CODE_W-1:0]   i_cfg_target,
  input  logic [2:0]          i_rd_ch,
  output logic [CODE_W-1:0]   o_rd_code,
  output logic [NUM_CH-1:0]   o_at_target,
  output logic                o_busy,
  spi_ldo_ramp_sequencer_if.master cmd
);

  localparam int         GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

  logic [CODE_W-1:0] r_current [NUM_CH];
  logic [CODE_W-1:0] r_target  [NUM_CH];
  logic [NUM_CH-1:0] r_force;

  logic [2:0]        r_state;
  logic [2:0]        r_scan_ptr;
  logic [2:0]        r_scan_idx;
  logic [2:0]        r_scan_cnt;
  logic [2:0]        r_ch;
  logic [CODE_W-1:0] r_next;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_wr_en;
  logic [31:0]       r_wr_data;

  logic [NUM_CH-1:0] w_at_target;
  logic [NUM_CH-1:0] w_need;
  logic [CODE_W-1:0] w_cur_sel;
  logic [CODE_W-1:0] w_tgt_sel;
  logic [CODE_W-1:0] w_step_next;
  logic [7:0]        w_ss_onehot;
  logic [31:0]       w_word;
  logic              w_cfg_valid;
  logic              w_refresh;

  assign w_cfg_valid = i_cfg_we && (int'(i_cfg_ch) < NUM_CH);

  // A channel is settled only when its code matches and no forced rewrite is pending.
  always_comb begin
    w_at_target = '0;
    w_need      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_at_target[i] = (r_current[i] == r_target[i]) && !r_force[i];
      w_need[i]      = !w_at_target[i];
    end
  end

  // Readback mux; an out-of-range channel reads as zero.
  always_comb begin
    o_rd_code = '0;
    if (int'(i_rd_ch) < NUM_CH) begin
      o_rd_code = r_current[i_rd_ch];
    end
  end

  assign w_cur_sel = r_current[r_ch];
  assign w_tgt_sel = r_target[r_ch];

  spi_ldo_step_calc #(
    .CODE_W (CODE_W),
    .STEP   (STEP)
  ) u_step_calc (
    .i_current (w_cur_sel),
    .i_target  (w_tgt_sel),
    .o_next    (w_step_next)
  );

  assign w_ss_onehot = 8'(1) << r_ch;
  assign w_word      = (32'(w_step_next) << DATA_LSB) | (32'(w_ss_onehot) << SS_LSB);

`ifdef LDO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);

  logic [REF_W-1:0] r_idle_cnt;
  logic             w_idle_quiet;

  assign w_idle_quiet = (r_state == S_IDLE) && (&w_at_target);
  assign w_refresh    = w_idle_quiet && !i_cfg_we &&
                        (r_idle_cnt == REF_W'(REFRESH_CYCLES - 1));

  // Count quiet idle cycles; any config write or activity restarts the interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (i_cfg_we || !w_idle_quiet || w_refresh) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + REF_W'(1);
    end
  end
`else
  assign w_refresh = 1'b0;
`endif

  // Per-channel register file: host writes targets, issue commits the stepped code.
  // The force flags make every channel get written once after reset or refresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_current[i] <= CODE_W'(INIT_CODE);
        r_target[i]  <= CODE_W'(INIT_CODE);
      end
      r_force <= '1;
    end else begin
      if (w_cfg_valid) begin
        r_target[i_cfg_ch] <= i_cfg_target;
      end
      if (r_state == S_ISSUE) begin
        r_current[r_ch] <= r_next;
        r_force[r_ch]   <= 1'b0;
      end else if (w_refresh) begin
        r_force <= '1;
      end
    end
  end

  // Sequencer FSM flow:
  //   round-robin scan for a channel needing service,
  //   compute its step,
  //   issue one command,
  //   then hold off for the inter-command gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_scan_ptr <= '0;
      r_scan_idx <= '0;
      r_scan_cnt <= '0;
      r_ch       <= '0;
      r_next     <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable && (|w_need)) begin
            r_state    <= S_SCAN;
            r_scan_idx <= r_scan_ptr;
            r_scan_cnt <= '0;
          end
        end
        S_SCAN: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
          end else if (w_need[r_scan_idx]) begin
            r_ch    <= r_scan_idx;
            r_state <= S_STEP;
          end else if (r_scan_cnt == CH_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_scan_idx <= (r_scan_idx == CH_LAST) ? 3'd0 : (r_scan_idx + 3'd1);
            r_scan_cnt <= r_scan_cnt + 3'd1;
          end
        end
        S_STEP: begin
          r_next  <= w_step_next;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_scan_ptr <= (r_ch == CH_LAST) ? 3'd0 : (r_ch + 3'd1);
          r_gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
          r_state    <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state    <= i_enable ? S_SCAN : S_IDLE;
            r_scan_idx <= r_scan_ptr;
            r_scan_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Command outputs are registered so the push pulse lines up exactly with the issue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= (r_state == S_STEP);
      if (r_state == S_STEP) begin
        r_wr_data <= w_word;
      end
    end
  end

  assign cmd.spi_wr_en   = r_wr_en;
  assign cmd.spi_wr_data = r_wr_data;
  assign o_at_target     = w_at_target;
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_ldo_ramp_sequencer.sv
// Bench for the LDO ramp sequencer.
// Expected command words are queued as stimulus is applied and compared on every push pulse.
module tb_spi_ldo_ramp_sequencer;

  localparam int NUM_CH         = 8;
  localparam int CODE_W         = 11;
  localparam int STEP           = 16;
  localparam int GAP_CYCLES     = 20;
  localparam int INIT_CODE      = 0;
  localparam int REFRESH_CYCLES = 200;
  localparam int DRAIN_BUDGET   = 20 * (GAP_CYCLES + 12);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              cfgWe = 1'b0;
  logic [2:0]        cfgCh = '0;
  logic [CODE_W-1:0] cfgTarget = '0;
  logic [2:0]        rdCh = '0;
  logic [CODE_W-1:0] rdCode;
  logic [NUM_CH-1:0] atTarget;
  logic              busy;

  spi_ldo_ramp_sequencer_if cmdIf();

  spi_ldo_ramp_sequencer #(
    .NUM_CH         (NUM_CH),
    .CODE_W         (CODE_W),
    .STEP           (STEP),
    .GAP_CYCLES     (GAP_CYCLES),
    .INIT_CODE      (INIT_CODE),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .i_cfg_we     (cfgWe),
    .i_cfg_ch     (cfgCh),
    .i_cfg_target (cfgTarget),
    .i_rd_ch      (rdCh),
    .o_rd_code    (rdCode),
    .o_at_target  (atTarget),
    .o_busy       (busy),
    .cmd          (cmdIf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int lastPulse = -1;
  int cfgEdge = 0;
  bit latPending = 1'b0;
  int pulseCount = 0;
  int tbCode [NUM_CH];
  logic [31:0] expQ [$];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mkWord(input int ch, input int code);
    mkWord = (32'(code) << 16) | (32'(1) << ch);
  endfunction

  task automatic pushWord(input int ch, input int code);
    expQ.push_back(mkWord(ch, code));
    tbCode[ch] = code;
  endtask

  task automatic applyStimulus(input int ch, input int tgt, input bit measureLat);
    cfgCh = 3'(ch);
    cfgTarget = CODE_W'(tgt);
    cfgWe = 1'b1;
    @(posedge clk); #1;
    cfgWe = 1'b0;
    if (measureLat) begin
      cfgEdge = cycleCnt;
      latPending = 1'b1;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checkOutput("drain_timeout", 32'(expQ.size()) | 32'h8000_0000, 0);
      expQ.delete();
    end
  endtask

  task automatic checkRead(input int ch, input int want);
    rdCh = 3'(ch);
    #1;
    checkOutput($sformatf("rd_code_ch%0d", ch), 32'(rdCode), 32'(want));
  endtask

  // Scoreboard monitor: every push pulse must match the next queued word and respect pacing.
  always @(negedge clk) begin
    if (!rst && cmdIf.spi_wr_en) begin
      pulseCount++;
      if (lastPulse >= 0)
        checkOutput("pulse_spacing", 32'((cycleCnt - lastPulse) >= GAP_CYCLES + 2), 32'd1);
      lastPulse = cycleCnt;
      if (latPending) begin
        checkOutput("cfg_latency", 32'((cycleCnt - cfgEdge) <= 2 + NUM_CH), 32'd1);
        latPending = 1'b0;
      end
      if (expQ.size() == 0)
        checkOutput("unexpected_pulse", cmdIf.spi_wr_data, 32'hFFFF_FFFF);
      else
        checkOutput("cmd_word", cmdIf.spi_wr_data, expQ.pop_front());
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    for (int i = 0; i < NUM_CH; i++) tbCode[i] = INIT_CODE;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_wr_en", 32'(cmdIf.spi_wr_en), 0);
    checkOutput("reset_wr_data", cmdIf.spi_wr_data, 0);
    checkOutput("reset_at_target", 32'(atTarget), 0);
    checkRead(3, 0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_without_enable", 32'(busy), 0);

    $display("[TB] Phase: forced initial write of every channel");
    for (int ch = 0; ch < NUM_CH; ch++) pushWord(ch, 0);
    enable = 1'b1;
    waitDrain(DRAIN_BUDGET);
    checkOutput("init_at_target", 32'(atTarget), 32'hFF);

    $display("[TB] Phase: interleaved ramps on ch1 and ch6");
    pushWord(1, 16); pushWord(6, 16); pushWord(1, 32);
    pushWord(6, 20); pushWord(1, 48); pushWord(1, 50);
    applyStimulus(1, 50, 1'b1);
    applyStimulus(6, 20, 1'b1);
    waitDrain(DRAIN_BUDGET);
    checkRead(1, 50);
    checkRead(6, 20);

    $display("[TB] Phase: ch2 ramp up to 40");
    pushWord(2, 16); pushWord(2, 32); pushWord(2, 40);
    applyStimulus(2, 40, 1'b1);
    waitDrain(DRAIN_BUDGET);
    checkRead(2, 40);
    checkOutput("ch2_at_target", 32'(atTarget[2]), 1);

    $display("[TB] Phase: ch5 up to 100 then down to 70");
    for (int c = 16; c <= 96; c += 16) pushWord(5, c);
    pushWord(5, 100);
    applyStimulus(5, 100, 1'b1);
    waitDrain(DRAIN_BUDGET);
    pushWord(5, 84); pushWord(5, 70);
    applyStimulus(5, 70, 1'b1);
    waitDrain(DRAIN_BUDGET);
    checkRead(5, 70);
    checkOutput("all_at_target", 32'(atTarget), 32'hFF);

    $display("[TB] Phase: retarget ch3 during its issue cycle");
    pushWord(3, 16); pushWord(3, 20);
    applyStimulus(3, 64, 1'b1);
    n = 0;
    while (!cmdIf.spi_wr_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("issue_wait_timeout", 32'(n >= 100), 0);
    cfgCh = 3'd3;
    cfgTarget = CODE_W'(20);
    cfgWe = 1'b1;
    @(posedge clk); #1;
    cfgWe = 1'b0;
    waitDrain(DRAIN_BUDGET);
    checkRead(3, 20);

    $display("[TB] Phase: drop enable mid-ramp on ch4");
    base = pulseCount;
    pushWord(4, 16); pushWord(4, 32);
    applyStimulus(4, 200, 1'b1);
    n = 0;
    while (pulseCount < base + 2 && n < 10 * GAP_CYCLES) begin
      @(negedge clk);
      n++;
    end
    checkOutput("second_pulse_timeout", 32'(n >= 10 * GAP_CYCLES), 0);
    enable = 1'b0;
    repeat (4 * GAP_CYCLES) @(posedge clk);
    #1;
    checkOutput("disabled_queue_empty", 32'(expQ.size()), 0);
    checkOutput("disabled_busy", 32'(busy), 0);
    checkOutput("disabled_ch4_pending", 32'(atTarget[4]), 0);
    checkRead(4, 32);
    for (int c = 48; c <= 192; c += 16) pushWord(4, c);
    pushWord(4, 200);
    enable = 1'b1;
    waitDrain(DRAIN_BUDGET);
    checkRead(4, 200);

`ifdef LDO_REFRESH_EN
    $display("[TB] Phase: idle refresh rewrites every channel");
    for (int k = 0; k < NUM_CH; k++) pushWord((5 + k) % NUM_CH, tbCode[(5 + k) % NUM_CH]);
    waitDrain(REFRESH_CYCLES + DRAIN_BUDGET);
    checkOutput("refresh_at_target", 32'(atTarget), 32'hFF);
`else
    $display("[TB] Phase: long idle without refresh");
    repeat (3 * REFRESH_CYCLES) @(posedge clk);
    #1;
    checkOutput("idle_no_activity", 32'(busy), 0);
    checkOutput("idle_at_target", 32'(atTarget), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
